// File: rtl/dmux8_scheduler.sv
// Valid/ready front end for the 8-way demux: one-entry holding register,
// addressed or round-robin lane choice, one-hot registered lane strobes.
module dmux8_scheduler #(
  parameter int WIDTH     = 16,
  parameter int NUM_LANES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in,
  input  logic                 in_addressed,
  input  logic [2:0]           in_dest,
  output logic [WIDTH-1:0]     out,
  output logic [2:0]           sel,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready,
  output logic                 busy,
  output logic [15:0]          sent_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [2:0]       lane;
  } hold_t;

  state_t     state;
  hold_t      hold;
  logic [2:0] rr_ptr;
  logic [2:0] nsel;
  logic       deliver;
  logic       xfer;

  assign deliver  = (state == FULL) && out_ready[hold.lane];
  assign in_ready = !reset && ((state == EMPTY) || out_ready[hold.lane]);
  assign xfer     = in_valid && in_ready;
  assign nsel     = in_addressed ? in_dest : rr_ptr;

  assign out  = hold.data;
  assign sel  = hold.lane;
  assign busy = (state == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      hold       <= '0;
      rr_ptr     <= '0;
      sent_count <= '0;
    end else begin
      if (deliver) sent_count <= sent_count + 16'd1;
      if (xfer) begin
        state     <= FULL;
        hold.data <= in;
        hold.lane <= nsel;
        if (!in_addressed) rr_ptr <= rr_ptr + 3'd1;
      end else if (deliver) begin
        state <= EMPTY;
      end
    end
  end

  // Per-lane strobe: set on accept to that lane, cleared when the word leaves.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    always_ff @(posedge clk) begin
      if (reset)        out_valid[i] <= 1'b0;
      else if (xfer)    out_valid[i] <= (nsel == 3'(i));
      else if (deliver) out_valid[i] <= 1'b0;
    end
  end

endmodule
